// File: rtl/polar_to_complex_if.sv
// polar_to_complex_if: sample bus of the polar-to-I/Q CORDIC rotator.
// Ports: mag, phase, input_strobe (master->slave); i, q, output_strobe (slave->master).
interface polar_to_complex_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]        mag;
    logic [15:0]                  phase;
    logic                         input_strobe;
    logic signed [DATA_WIDTH+1:0] i;
    logic signed [DATA_WIDTH+1:0] q;
    logic                         output_strobe;

    modport master (
        output mag, phase, input_strobe,
        input  i, q, output_strobe
    );

    modport slave (
        input  mag, phase, input_strobe,
        output i, q, output_strobe
    );
endinterface

// File: rtl/polar_to_complex.sv
// polar_to_complex: pipelined CORDIC rotator, magnitude/phase in, I/Q out.
// Ports: clock, reset (sync, active-high), enable, bus (slave: mag/phase/
// input_strobe in, i/q/output_strobe out). Option: POLAR_GAIN_COMP_EN adds a
// gain-compensation stage (x0.6074) and one cycle of latency.
module polar_to_complex #(
    parameter int DATA_WIDTH = 16,
    parameter int ITERATIONS = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    polar_to_complex_if.slave bus
);
    localparam int W  = DATA_WIDTH + 3;
    localparam int OW = DATA_WIDTH + 2;
    localparam int N  = ITERATIONS;
    localparam logic signed [15:0] QTR = 16'sh4000;

    function automatic logic signed [15:0] atan_rom(input int k);
        case (k)
            0:       return 16'sd8192;
            1:       return 16'sd4836;
            2:       return 16'sd2555;
            3:       return 16'sd1297;
            4:       return 16'sd651;
            5:       return 16'sd326;
            6:       return 16'sd163;
            7:       return 16'sd81;
            8:       return 16'sd41;
            9:       return 16'sd20;
            10:      return 16'sd10;
            11:      return 16'sd5;
            12:      return 16'sd3;
            13:      return 16'sd1;
            14:      return 16'sd1;
            default: return 16'sd0;
        endcase
    endfunction

    // Index 0 is the pre-rotation stage; index k+1 holds iteration k.
    logic signed [W-1:0] x_q [0:N];
    logic signed [W-1:0] x_d [0:N];
    logic signed [W-1:0] y_q [0:N];
    logic signed [W-1:0] y_d [0:N];
    logic signed [15:0]  z_q [0:N];
    logic signed [15:0]  z_d [0:N];
    logic                v_q [0:N];
    logic                v_d [0:N];

    logic signed [15:0]  ph;
    logic signed [W-1:0] m_ext;

    assign ph    = bus.phase;
    assign m_ext = {3'b000, bus.mag};

    always_comb begin
        // Fold the phase into +-90 deg so the micro-rotations converge.
        x_d[0] = m_ext;
        y_d[0] = '0;
        z_d[0] = ph;
        if (ph >= QTR) begin
            x_d[0] = '0;
            y_d[0] = m_ext;
            z_d[0] = ph - QTR;
        end else if (ph < -QTR) begin
            x_d[0] = '0;
            y_d[0] = -m_ext;
            z_d[0] = ph + QTR;
        end
        v_d[0] = bus.input_strobe;
        for (int k = 0; k < N; k++) begin
            if (z_q[k][15]) begin
                x_d[k+1] = x_q[k] + (y_q[k] >>> k);
                y_d[k+1] = y_q[k] - (x_q[k] >>> k);
                z_d[k+1] = z_q[k] + atan_rom(k);
            end else begin
                x_d[k+1] = x_q[k] - (y_q[k] >>> k);
                y_d[k+1] = y_q[k] + (x_q[k] >>> k);
                z_d[k+1] = z_q[k] - atan_rom(k);
            end
            v_d[k+1] = v_q[k];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k <= N; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
                z_q[k] <= '0;
                v_q[k] <= 1'b0;
            end
        end else if (enable) begin
            for (int k = 0; k <= N; k++) begin
                x_q[k] <= x_d[k];
                y_q[k] <= y_d[k];
                z_q[k] <= z_d[k];
                v_q[k] <= v_d[k];
            end
        end
    end

    logic signed [W-1:0] xo;
    logic signed [W-1:0] yo;
    logic                vo;

`ifdef POLAR_GAIN_COMP_EN
    // K = 1/2 + 1/8 - 1/64 - 1/512 cancels the CORDIC gain.
    function automatic logic signed [W-1:0] gain_k(input logic signed [W-1:0] a);
        return (a >>> 1) + (a >>> 3) - (a >>> 6) - (a >>> 9);
    endfunction

    logic signed [W-1:0] xg_q;
    logic signed [W-1:0] yg_q;
    logic                vg_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            xg_q <= '0;
            yg_q <= '0;
            vg_q <= 1'b0;
        end else if (enable) begin
            xg_q <= gain_k(x_q[N]);
            yg_q <= gain_k(y_q[N]);
            vg_q <= v_q[N];
        end
    end

    assign xo = xg_q;
    assign yo = yg_q;
    assign vo = vg_q;
`else
    assign xo = x_q[N];
    assign yo = y_q[N];
    assign vo = v_q[N];
`endif

    logic signed [OW-1:0] i_q;
    logic signed [OW-1:0] q_q;
    logic                 ov_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            i_q  <= '0;
            q_q  <= '0;
            ov_q <= 1'b0;
        end else if (enable) begin
            i_q  <= xo[OW-1:0];
            q_q  <= yo[OW-1:0];
            ov_q <= vo;
        end
    end

    // A held result is shown only in the enabled cycle that retires it,
    // so each sample strobes exactly once even across stalls.
    assign bus.i             = i_q;
    assign bus.q             = q_q;
    assign bus.output_strobe = ov_q & enable;

    // Top bits are guard bits (never set for legal inputs); residual z unused.
    logic unused_bits;
    assign unused_bits = ^{xo[W-1:OW], yo[W-1:OW], z_q[N]};
endmodule
